byte_serial_add_ctrl: RTL and testbench

- Sequencer that performs WIDTH-bit add/subtract by iterating one 8-bit carry-lookahead slice over the operand bytes, least-significant byte first.
- Carry is registered between iterations.
- Sits in the ALU as a low-area alternative to the full-width adder; multi-cycle ops are issued by the execute stage over a valid/ready handshake.

---
 rtl/alu_seq_pkg.sv | 20 ++
 rtl/byte_add_slice.sv | 47 ++++
 rtl/byte_serial_add_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_byte_serial_add_ctrl.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg
// Shared definitions for the multi-cycle ALU sequencers: the controller
// FSM state encoding, the slice width, and a helper that derives the number
// of byte iterations from an operand width.
package alu_seq_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_e;

  // Number of byte slices needed to cover an operand of the given width.
  function automatic int nbytes_f(input int width);
    return width / BYTE_W;
  endfunction

endpackage

// File: rtl/byte_add_slice.sv
// byte_add_slice
// Purely combinational 8-bit adder slice. Produces the byte sum for a given
// carry-in together with the group propagate/generate terms, so the caller
// can form the slice carry-out as g | (p & cin) without waiting on the sum.
//
// Ports:
//   a, b  : input  [BYTE_W-1:0]  operand bytes (b already inverted for subtract)
//   cin   : input                carry into bit 0
//   sum   : output [BYTE_W-1:0]  a + b + cin (low 8 bits)
//   p     : output               group propagate (all bits propagate)
//   g     : output               group generate (carry out independent of cin)
module byte_add_slice
  import alu_seq_pkg::*;
(
  input  logic [BYTE_W-1:0] a,
  input  logic [BYTE_W-1:0] b,
  input  logic              cin,
  output logic [BYTE_W-1:0] sum,
  output logic              p,
  output logic              g
);

  logic [BYTE_W-1:0] bit_g;
  logic [BYTE_W-1:0] bit_p;
  logic [BYTE_W-1:0] carry;
  logic              group_g;

  // Group generate is the carry out of the byte assuming cin = 0; the
  // per-bit carries for the sum do include cin.
  always_comb begin
    bit_g    = a & b;
    bit_p    = a ^ b;
    carry    = '0;
    carry[0] = cin;
    for (int i = 1; i < BYTE_W; i++) begin
      carry[i] = bit_g[i-1] | (bit_p[i-1] & carry[i-1]);
    end
    group_g = 1'b0;
    for (int i = 0; i < BYTE_W; i++) begin
      group_g = bit_g[i] | (bit_p[i] & group_g);
    end
    sum = bit_p ^ carry;
    p   = &bit_p;
    g   = group_g;
  end

endmodule

// File: rtl/byte_serial_add_ctrl.sv
// byte_serial_add_ctrl
// Low-area WIDTH-bit add/subtract unit. One 8-bit slice is reused over the
// operand bytes, least-significant first, with the carry registered between
// iterations. Operations arrive and results leave over valid/ready handshakes.
//
// Ports:
//   clock      : input               rising-edge clock
//   reset_n    : input               asynchronous active-low reset
//   in_valid   : input               operation request
//   in_ready   : output              controller idle and able to accept
//   op_a       : input  [WIDTH-1:0]  operand A
//   op_b       : input  [WIDTH-1:0]  operand B
//   op_sub     : input               1 = A - B, 0 = A + B
//   out_valid  : output              result available
//   out_ready  : input               consumer accepts result
//   result     : output [WIDTH-1:0]  sum / difference
//   carry_out  : output              carry out of MSB (subtract: 1 = no borrow)
//   overflow   : output              signed overflow
//   busy       : output              FSM not idle
//
// Build option:
//   BYTE_SERIAL_SAT_EN  when defined, a signed overflow clamps the result to
//                       the most positive / most negative value according to
//                       the sign of operand A. Otherwise the result wraps.
module byte_serial_add_ctrl
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             op_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic             busy
);

  localparam int NBYTES = nbytes_f(WIDTH);
  localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

  generate
    if (WIDTH < BYTE_W || (WIDTH % BYTE_W) != 0) begin : g_bad_width
      $error("byte_serial_add_ctrl: WIDTH must be a non-zero multiple of 8");
    end
  endgenerate

  seq_state_e       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_out_q, carry_out_d;
  logic             overflow_q, overflow_d;

  logic [BYTE_W-1:0] a_byte;
  logic [BYTE_W-1:0] b_byte;
  logic [BYTE_W-1:0] sum_byte;
  logic              slice_p;
  logic              slice_g;
  logic              slice_cout;
  logic              msb_cin;

  always_comb begin
    a_byte = '0;
    b_byte = '0;
    for (int i = 0; i < NBYTES; i++) begin
      if (idx_q == IDX_W'(i)) begin
        a_byte = a_q[i*BYTE_W +: BYTE_W];
        b_byte = b_q[i*BYTE_W +: BYTE_W];
      end
    end
  end

  byte_add_slice u_slice (
    .a   (a_byte),
    .b   (b_byte),
    .cin (carry_q),
    .sum (sum_byte),
    .p   (slice_p),
    .g   (slice_g)
  );

  // The carry into the top bit of the byte is recovered from the sum bit:
  // sum[7] = a[7] ^ b[7] ^ c7, so c7 = sum[7] ^ a[7] ^ b[7].
  assign slice_cout = slice_g | (slice_p & carry_q);
  assign msb_cin    = sum_byte[BYTE_W-1] ^ a_byte[BYTE_W-1] ^ b_byte[BYTE_W-1];

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    carry_d     = carry_q;
    a_d         = a_q;
    b_d         = b_q;
    result_d    = result_q;
    carry_out_d = carry_out_q;
    overflow_d  = overflow_q;

    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          // Subtract is A + ~B + 1: invert B here and seed the carry with 1.
          a_d     = op_a;
          b_d     = op_sub ? ~op_b : op_b;
          carry_d = op_sub;
          idx_d   = '0;
          state_d = RUN;
        end
      end

      RUN: begin
        for (int i = 0; i < NBYTES; i++) begin
          if (idx_q == IDX_W'(i)) begin
            result_d[i*BYTE_W +: BYTE_W] = sum_byte;
          end
        end
        carry_d = slice_cout;
        if (idx_q == LAST_IDX) begin
          carry_out_d = slice_cout;
          overflow_d  = msb_cin ^ slice_cout;
`ifdef BYTE_SERIAL_SAT_EN
          if ((msb_cin ^ slice_cout) == 1'b1) begin
            result_d = a_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                    : {1'b0, {(WIDTH-1){1'b1}}};
          end
`endif
          state_d = DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end

      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      result_q    <= '0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      carry_q     <= carry_d;
      a_q         <= a_d;
      b_q         <= b_d;
      result_q    <= result_d;
      carry_out_q <= carry_out_d;
      overflow_q  <= overflow_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign result    = result_q;
  assign carry_out = carry_out_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_byte_serial_add_ctrl.sv
// tb_byte_serial_add_ctrl
// Directed bench for byte_serial_add_ctrl (WIDTH = 32). A reference model
// computes each result from plain integer arithmetic; a compare process
// checks every cycle that out_valid is high, and each directed case also
// checks hand-computed literal values. Honors BYTE_SERIAL_SAT_EN like the DUT.
module tb_byte_serial_add_ctrl;

  localparam int WIDTH  = 32;
  localparam int NBYTES = WIDTH / 8;

  logic             clock = 1'b0;
  logic             reset_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             op_sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             carry_out;
  logic             overflow;
  logic             busy;

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] exp_result;
  logic             exp_carry;
  logic             exp_ovf;
  bit               exp_pending = 1'b0;

  always #5 clock = ~clock;

  byte_serial_add_ctrl #(.WIDTH(WIDTH)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .op_sub    (op_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .carry_out (carry_out),
    .overflow  (overflow),
    .busy      (busy)
  );

  task automatic checkOutput(input string name, input logic [WIDTH-1:0] act,
                             input logic [WIDTH-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: unsigned arithmetic for the result and carry, exact signed
  // arithmetic for overflow and saturation.
  task automatic modelOp(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic sub, output logic [WIDTH-1:0] res,
                         output logic c, output logic ov);
    longint sa, sb, exact;
    longint max_pos, min_neg;
    sa      = longint'($signed(a));
    sb      = longint'($signed(b));
    max_pos = (longint'(1) <<< (WIDTH - 1)) - 1;
    min_neg = -(longint'(1) <<< (WIDTH - 1));
    if (sub) begin
      res   = a - b;
      c     = (a >= b);
      exact = sa - sb;
    end else begin
      res   = a + b;
      c     = ({1'b0, a} + {1'b0, b}) > {1'b0, {WIDTH{1'b1}}};
      exact = sa + sb;
    end
    ov = (exact > max_pos) || (exact < min_neg);
`ifdef BYTE_SERIAL_SAT_EN
    if (ov) res = (exact > max_pos) ? WIDTH'(max_pos) : WIDTH'(min_neg);
`endif
  endtask

  always @(negedge clock) begin
    if (reset_n && out_valid) begin
      if (!exp_pending) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected out_valid: got 1, expected 0");
      end else begin
        checkOutput("model result", result, exp_result);
        checkOutput("model carry_out", carry_out, exp_carry);
        checkOutput("model overflow", overflow, exp_ovf);
      end
    end
  end

  always @(posedge clock) begin
    if (reset_n && out_valid && out_ready) exp_pending = 1'b0;
  end

  // Issues one op and returns at the first negedge with out_valid high.
  // lat counts cycles from the accept cycle to the first out_valid cycle.
  task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                               input logic sub, output int lat);
    int guard = 0;
    while (!in_ready && guard < 50) begin
      @(negedge clock);
      guard++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("[TB] FAIL in_ready timeout: got 0, expected 1");
    end
    op_a     = a;
    op_b     = b;
    op_sub   = sub;
    in_valid = 1'b1;
    modelOp(a, b, sub, exp_result, exp_carry, exp_ovf);
    exp_pending = 1'b1;
    @(negedge clock);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(negedge clock);
      lat++;
    end
    if (!out_valid) begin
      checks++;
      errors++;
      $display("[TB] FAIL out_valid timeout: got 0, expected 1");
    end
  endtask

  task automatic runCase(input string name, input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] b, input logic sub,
                         input logic [WIDTH-1:0] lit_res, input logic lit_c,
                         input logic lit_ov);
    int lat;
    applyStimulus(a, b, sub, lat);
    checkOutput({name, " result"}, result, lit_res);
    checkOutput({name, " carry_out"}, carry_out, lit_c);
    checkOutput({name, " overflow"}, overflow, lit_ov);
    checkOutput({name, " latency"}, lat, NBYTES + 1);
    @(negedge clock);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat;
    logic [WIDTH-1:0] sat_res;

    reset_n   = 1'b0;
    in_valid  = 1'b0;
    op_a      = '0;
    op_b      = '0;
    op_sub    = 1'b0;
    out_ready = 1'b1;

    @(negedge clock);
    checkOutput("reset result", result, 32'h0);
    checkOutput("reset carry_out", carry_out, 1'b0);
    checkOutput("reset overflow", overflow, 1'b0);
    checkOutput("reset out_valid", out_valid, 1'b0);
    checkOutput("reset busy", busy, 1'b0);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    checkOutput("post-reset in_ready", in_ready, 1'b1);

    runCase("add ff+1", 32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 1'b0);
    runCase("add ripple", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
`ifdef BYTE_SERIAL_SAT_EN
    sat_res = 32'h7FFF_FFFF;
`else
    sat_res = 32'h8000_0000;
`endif
    runCase("add ovf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, sat_res, 1'b0, 1'b1);
    runCase("sub 5-7", 32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
    runCase("sub equal", 32'h1234_5678, 32'h1234_5678, 1'b1, 32'h0000_0000, 1'b1, 1'b0);
`ifdef BYTE_SERIAL_SAT_EN
    sat_res = 32'h8000_0000;
`else
    sat_res = 32'h7FFF_FFFF;
`endif
    runCase("sub ovf", 32'h8000_0000, 32'h0000_0001, 1'b1, sat_res, 1'b1, 1'b1);
    runCase("add mixed", 32'h89AB_CDEF, 32'h7654_3211, 1'b0, 32'h0000_0000, 1'b1, 1'b0);

    // Backpressure: hold the result for 10 cycles while a request waits.
    out_ready = 1'b0;
    applyStimulus(32'h1111_1111, 32'h2222_2222, 1'b0, lat);
    checkOutput("bp latency", lat, NBYTES + 1);
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      op_a     = 32'hDEAD_0000 + i;
      op_b     = 32'h0000_BEEF;
      op_sub   = 1'b0;
      @(negedge clock);
      checkOutput("bp result held", result, 32'h3333_3333);
      checkOutput("bp in_ready low", in_ready, 1'b0);
      checkOutput("bp out_valid held", out_valid, 1'b1);
    end
    op_a      = 32'h0000_000A;
    op_b      = 32'h0000_0003;
    op_sub    = 1'b1;
    out_ready = 1'b1;
    @(negedge clock);
    checkOutput("bp retire out_valid", out_valid, 1'b0);
    checkOutput("bp bubble in_ready", in_ready, 1'b1);
    modelOp(op_a, op_b, op_sub, exp_result, exp_carry, exp_ovf);
    exp_pending = 1'b1;
    @(negedge clock);
    in_valid = 1'b0;
    checkOutput("bp next accepted", busy, 1'b1);
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(negedge clock);
      lat++;
    end
    checkOutput("bp next latency", lat, NBYTES + 1);
    checkOutput("bp next result", result, 32'h0000_0007);
    checkOutput("bp next carry_out", carry_out, 1'b1);
    @(negedge clock);

    // Abort in the second RUN cycle; byte 0 of the result is nonzero by then.
    op_a     = 32'h0102_0304;
    op_b     = 32'h1010_1010;
    op_sub   = 1'b0;
    in_valid = 1'b1;
    @(negedge clock);
    in_valid = 1'b0;
    @(posedge clock);
    #2;
    reset_n     = 1'b0;
    exp_pending = 1'b0;
    #1;
    checkOutput("abort result", result, 32'h0);
    checkOutput("abort carry_out", carry_out, 1'b0);
    checkOutput("abort overflow", overflow, 1'b0);
    checkOutput("abort out_valid", out_valid, 1'b0);
    checkOutput("abort busy", busy, 1'b0);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    checkOutput("abort in_ready", in_ready, 1'b1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      checkOutput("abort no out_valid", out_valid, 1'b0);
    end
    runCase("post-abort 1+1", 32'h0000_0001, 32'h0000_0001, 1'b0, 32'h0000_0002, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
